// File: rtl/mcu_status_rx.sv
// mcu_status_rx: 8N1 UART receiver for the MCU return line.
// It checks framing, decodes the MCU acknowledge byte and tracks the
// power-up reply window. That window produces the update_flag level and
// the status_valid / status_timeout events.
module mcu_status_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mcu_rx,
  input  logic       systerm_power_up,
  output logic [7:0] rx_byte,
  output logic       rx_byte_en,
  output logic       frame_err,
  output logic       update_flag,
  output logic       status_valid,
  output logic       status_timeout,
  output logic       mcu_ack
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [23:0]      TMO_LAST  = 24'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic W_OFF   = 1'b0;
  localparam logic W_ARMED = 1'b1;

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_en_q, byte_en_d;
  logic             ferr_q, ferr_d;

  logic             pu_q;
  logic             win_q, win_d;
  logic [23:0]      tmr_q, tmr_d;
  logic             flag_q, flag_d;
  logic             sv_q, sv_d;
  logic             to_q, to_d;
  logic             ack_q, ack_d;
  logic             rise;
  logic             reply;

  // Two-flop synchroniser; it resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= mcu_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM: mid-bit sampling that counts from the start-bit edge.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    sh_d      = sh_q;
    rx_byte_d = rx_byte_q;
    byte_en_d = 1'b0;
    ferr_d    = 1'b0;
    case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) st_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            st_d = S_IDLE;
          end else begin
            st_d  = S_DATA;
            idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          if (idx_q == 3'd7) st_d = S_STOP;
          else               idx_d = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_byte_d = sh_q;
            byte_en_d = 1'b1;
            st_d      = S_IDLE;
          end else begin
            ferr_d = 1'b1;
            st_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Receiver control state and its registered byte/pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      rx_byte_q <= 8'h00;
      byte_en_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      rx_byte_q <= rx_byte_d;
      byte_en_q <= byte_en_d;
      ferr_q    <= ferr_d;
    end
  end

  // Bit timing counter, bit index and shift register. These are qualified by
  // the FSM state, so they need no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    idx_q <= idx_d;
    sh_q  <= sh_d;
  end

  assign rise  = systerm_power_up & ~pu_q;
  assign reply = byte_en_q && (win_q == W_ARMED) &&
                 ((rx_byte_q == 8'h5A) || (rx_byte_q == 8'hA5));

  // Reply window and byte decode. A reply beats a same-cycle timeout, and
  // a power-up edge re-arms the window after any same-cycle resolution.
  always_comb begin
    win_d  = win_q;
    tmr_d  = tmr_q;
    flag_d = flag_q;
    sv_d   = 1'b0;
    to_d   = 1'b0;
    ack_d  = byte_en_q && (rx_byte_q == 8'h06);
    if (win_q == W_ARMED) begin
      tmr_d = tmr_q + 24'd1;
      if (reply) begin
        flag_d = (rx_byte_q == 8'h5A);
        sv_d   = 1'b1;
        win_d  = W_OFF;
      end else if (tmr_q == TMO_LAST) begin
        flag_d = 1'b0;
        to_d   = 1'b1;
        win_d  = W_OFF;
      end
    end
    if (rise) begin
      win_d = W_ARMED;
      tmr_d = 24'd0;
    end
  end

  // Window control state and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pu_q   <= 1'b0;
      win_q  <= W_OFF;
      flag_q <= 1'b0;
      sv_q   <= 1'b0;
      to_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      pu_q   <= systerm_power_up;
      win_q  <= win_d;
      flag_q <= flag_d;
      sv_q   <= sv_d;
      to_q   <= to_d;
      ack_q  <= ack_d;
    end
  end

  // The window timer only counts while armed and is cleared on arming.
  always_ff @(posedge clk) begin
    tmr_q <= tmr_d;
  end

  assign rx_byte        = rx_byte_q;
  assign rx_byte_en     = byte_en_q;
  assign frame_err      = ferr_q;
  assign update_flag    = flag_q;
  assign status_valid   = sv_q;
  assign status_timeout = to_q;
  assign mcu_ack        = ack_q;

endmodule

// File: tb/tb_mcu_status_rx.sv
// Directed testbench for mcu_status_rx (16 clk per bit, 1000-clk window).
module tb_mcu_status_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       mcu_rx;
  logic       systerm_power_up;
  logic [7:0] rx_byte;
  logic       rx_byte_en;
  logic       frame_err;
  logic       update_flag;
  logic       status_valid;
  logic       status_timeout;
  logic       mcu_ack;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_en = 0, n_ferr = 0, n_sv = 0, n_to = 0, n_ack = 0;
  int en_cyc = 0, sv_cyc = 0, to_cyc = 0, ack_cyc = 0;
  logic [7:0] en_byte = 8'h00;

  mcu_status_rx #(.CLKS_PER_BIT(16), .TIMEOUT_CLKS(1000)) dut (
    .clk(clk), .rst(rst), .mcu_rx(mcu_rx), .systerm_power_up(systerm_power_up),
    .rx_byte(rx_byte), .rx_byte_en(rx_byte_en), .frame_err(frame_err),
    .update_flag(update_flag), .status_valid(status_valid),
    .status_timeout(status_timeout), .mcu_ack(mcu_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_byte_en) begin n_en <= n_en + 1; en_cyc <= cyc; en_byte <= rx_byte; end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (status_valid) begin n_sv <= n_sv + 1; sv_cyc <= cyc; end
    if (status_timeout) begin n_to <= n_to + 1; to_cyc <= cyc; end
    if (mcu_ack) begin n_ack <= n_ack + 1; ack_cyc <= cyc; end
  end

  task automatic idle(input int n);
    mcu_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopv, output int tf);
    @(negedge clk);
    tf = cyc;
    mcu_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mcu_rx = b[i];
      repeat (16) @(negedge clk);
    end
    mcu_rx = stopv;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mcu_rx = 1'b1; systerm_power_up = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
    checks++; if (rx_byte_en !== 1'b0) begin errors++; $display("FAIL reset_rx_byte_en got %b want 0", rx_byte_en); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL reset_update_flag got %b want 0", update_flag); end
    checks++; if (status_valid !== 1'b0) begin errors++; $display("FAIL reset_status_valid got %b want 0", status_valid); end
    checks++; if (status_timeout !== 1'b0) begin errors++; $display("FAIL reset_status_timeout got %b want 0", status_timeout); end
    checks++; if (mcu_ack !== 1'b0) begin errors++; $display("FAIL reset_mcu_ack got %b want 0", mcu_ack); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_basic_rx;
    int tf, e0, f0;
    e0 = n_en; f0 = n_ferr;
    send_byte(8'h3C, 1'b1, tf);
    idle(20);
    checks++; if (n_en - e0 !== 1) begin errors++; $display("FAIL basic_en_count got %0d want 1", n_en - e0); end
    checks++; if (en_byte !== 8'h3C) begin errors++; $display("FAIL basic_byte got %h want 3c", en_byte); end
    checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL basic_rx_byte got %h want 3c", rx_byte); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", n_ferr - f0); end
    // 2 sync + 8 half bit + 9*16 + 1 output register
    checks++; if (en_cyc - tf !== 155) begin errors++; $display("FAIL basic_latency got %0d want 155", en_cyc - tf); end
  endtask

  task automatic test_reply;
    int tf, s0, e0;
    @(negedge clk); systerm_power_up = 1'b1;
    idle(5);
    s0 = n_sv;
    send_byte(8'h3C, 1'b1, tf);
    idle(20);
    checks++; if (n_sv - s0 !== 0) begin errors++; $display("FAIL reply_other_sv got %0d want 0", n_sv - s0); end
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL reply_other_flag got %b want 0", update_flag); end
    send_byte(8'h5A, 1'b1, tf);
    idle(20);
    checks++; if (n_sv - s0 !== 1) begin errors++; $display("FAIL reply_5a_sv got %0d want 1", n_sv - s0); end
    checks++; if (update_flag !== 1'b1) begin errors++; $display("FAIL reply_5a_flag got %b want 1", update_flag); end
    checks++; if (sv_cyc - en_cyc !== 1) begin errors++; $display("FAIL reply_5a_latency got %0d want 1", sv_cyc - en_cyc); end
    systerm_power_up = 1'b0;
    idle(5);
    systerm_power_up = 1'b1;
    idle(5);
    s0 = n_sv; e0 = n_en;
    send_byte(8'hA5, 1'b1, tf);
    idle(20);
    checks++; if (n_sv - s0 !== 1) begin errors++; $display("FAIL reply_a5_sv got %0d want 1", n_sv - s0); end
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL reply_a5_flag got %b want 0", update_flag); end
    checks++; if (n_en - e0 !== 1) begin errors++; $display("FAIL reply_a5_en got %0d want 1", n_en - e0); end
    systerm_power_up = 1'b0;
    idle(5);
  endtask

  task automatic test_timeout;
    int tf, c0, t0, s0;
    systerm_power_up = 1'b1;
    idle(5);
    send_byte(8'h5A, 1'b1, tf);
    idle(20);
    checks++; if (update_flag !== 1'b1) begin errors++; $display("FAIL tmo_setup_flag got %b want 1", update_flag); end
    systerm_power_up = 1'b0;
    idle(5);
    t0 = n_to;
    c0 = cyc;
    systerm_power_up = 1'b1;
    repeat (1000) @(negedge clk);
    checks++; if (n_to - t0 !== 0) begin errors++; $display("FAIL tmo_early got %0d want 0", n_to - t0); end
    repeat (100) @(negedge clk);
    checks++; if (n_to - t0 !== 1) begin errors++; $display("FAIL tmo_count got %0d want 1", n_to - t0); end
    checks++; if (to_cyc - c0 !== 1001) begin errors++; $display("FAIL tmo_latency got %0d want 1001", to_cyc - c0); end
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL tmo_flag got %b want 0", update_flag); end
    s0 = n_sv;
    send_byte(8'h5A, 1'b1, tf);
    idle(20);
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL off_5a_flag got %b want 0", update_flag); end
    checks++; if (n_sv - s0 !== 0) begin errors++; $display("FAIL off_5a_sv got %0d want 0", n_sv - s0); end
    systerm_power_up = 1'b0;
    idle(5);
  endtask

  task automatic test_frame_err;
    int tf, e0, f0, a0;
    e0 = n_en; f0 = n_ferr; a0 = n_ack;
    send_byte(8'h81, 1'b0, tf);
    mcu_rx = 1'b0;
    repeat (640) @(negedge clk);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", n_ferr - f0); end
    checks++; if (n_en - e0 !== 0) begin errors++; $display("FAIL ferr_no_byte got %0d want 0", n_en - e0); end
    idle(32);
    send_byte(8'h06, 1'b1, tf);
    idle(20);
    checks++; if (n_en - e0 !== 1) begin errors++; $display("FAIL ack_en got %0d want 1", n_en - e0); end
    checks++; if (rx_byte !== 8'h06) begin errors++; $display("FAIL ack_byte got %h want 06", rx_byte); end
    checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL ack_count got %0d want 1", n_ack - a0); end
    checks++; if (ack_cyc - en_cyc !== 1) begin errors++; $display("FAIL ack_latency got %0d want 1", ack_cyc - en_cyc); end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_after got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_glitch;
    int tf, e0, f0, s0, a0;
    e0 = n_en; f0 = n_ferr; s0 = n_sv; a0 = n_ack;
    @(negedge clk);
    mcu_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    checks++; if ((n_en - e0) + (n_ferr - f0) + (n_sv - s0) + (n_ack - a0) !== 0) begin
      errors++; $display("FAIL glitch_pulses got %0d want 0", (n_en - e0) + (n_ferr - f0) + (n_sv - s0) + (n_ack - a0));
    end
    send_byte(8'hC3, 1'b1, tf);
    idle(20);
    checks++; if (rx_byte !== 8'hC3) begin errors++; $display("FAIL glitch_recover got %h want c3", rx_byte); end
    checks++; if (en_cyc - tf !== 155) begin errors++; $display("FAIL glitch_latency got %0d want 155", en_cyc - tf); end
  endtask

  task automatic test_reset_midframe;
    int tf, e0, f0, s0;
    logic [7:0] b;
    systerm_power_up = 1'b1;
    idle(5);
    send_byte(8'h5A, 1'b1, tf);
    idle(20);
    systerm_power_up = 1'b0;
    idle(5);
    checks++; if (update_flag !== 1'b1) begin errors++; $display("FAIL mid_setup_flag got %b want 1", update_flag); end
    b = 8'h5A;
    mcu_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mcu_rx = b[i];
      repeat (16) @(negedge clk);
    end
    mcu_rx = b[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL mid_rst_byte got %h want 00", rx_byte); end
    checks++; if (update_flag !== 1'b0) begin errors++; $display("FAIL mid_rst_flag got %b want 0", update_flag); end
    rst = 1'b0;
    e0 = n_en; f0 = n_ferr; s0 = n_sv;
    idle(200);
    checks++; if ((n_en - e0) + (n_ferr - f0) !== 0) begin errors++; $display("FAIL mid_spurious got %0d want 0", (n_en - e0) + (n_ferr - f0)); end
    systerm_power_up = 1'b1;
    idle(5);
    send_byte(8'h5A, 1'b1, tf);
    idle(20);
    checks++; if (n_en - e0 !== 1) begin errors++; $display("FAIL mid_after_en got %0d want 1", n_en - e0); end
    checks++; if (rx_byte !== 8'h5A) begin errors++; $display("FAIL mid_after_byte got %h want 5a", rx_byte); end
    checks++; if (update_flag !== 1'b1) begin errors++; $display("FAIL mid_after_flag got %b want 1", update_flag); end
    checks++; if (n_sv - s0 !== 1) begin errors++; $display("FAIL mid_after_sv got %0d want 1", n_sv - s0); end
    systerm_power_up = 1'b0;
    idle(5);
  endtask

  initial begin
    rst = 1'b1;
    mcu_rx = 1'b1;
    systerm_power_up = 1'b0;
    test_reset;
    test_basic_rx;
    test_reply;
    test_timeout;
    test_frame_err;
    test_glitch;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
